// File: rtl/stack_memory_pkg.sv
// Shared encodings for the stack memory responder: op codes, fault codes, FSM states, default stack windows.
package stack_memory_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    localparam logic [1:0] FLT_NONE      = 2'd0;
    localparam logic [1:0] FLT_OVERFLOW  = 2'd1;
    localparam logic [1:0] FLT_UNDERFLOW = 2'd2;
    localparam logic [1:0] FLT_PRIV      = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    localparam int unsigned DEF_KERNEL_STACK_TOP    = 4096;
    localparam int unsigned DEF_KERNEL_STACK_BOTTOM = 6143;
    localparam int unsigned DEF_USER_STACK_TOP      = 6144;
    localparam int unsigned DEF_USER_STACK_BOTTOM   = 8191;

    function automatic logic op_is_write(input logic [1:0] op);
        return (op == OP_STORE) || (op == OP_PUSH);
    endfunction

    // PUSH and POP share the upper encoding bit.
    function automatic logic op_is_stack(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/stack_access_checker.sv
// Combinational access classifier: privilege, then stack overflow, then stack underflow.
module stack_access_checker
    import stack_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned KERNEL_STACK_TOP    = DEF_KERNEL_STACK_TOP,
    parameter int unsigned KERNEL_STACK_BOTTOM = DEF_KERNEL_STACK_BOTTOM,
    parameter int unsigned USER_STACK_TOP      = DEF_USER_STACK_TOP,
    parameter int unsigned USER_STACK_BOTTOM   = DEF_USER_STACK_BOTTOM
) (
    input  logic [1:0]            op_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic                  is_kernel_i,
    output logic                  fault_o,
    output logic [1:0]            fault_code_o
);

    localparam logic [ADDR_WIDTH-1:0] K_TOP = ADDR_WIDTH'(KERNEL_STACK_TOP);
    localparam logic [ADDR_WIDTH-1:0] K_BOT = ADDR_WIDTH'(KERNEL_STACK_BOTTOM);
    localparam logic [ADDR_WIDTH-1:0] U_TOP = ADDR_WIDTH'(USER_STACK_TOP);
    localparam logic [ADDR_WIDTH-1:0] U_BOT = ADDR_WIDTH'(USER_STACK_BOTTOM);

    logic [ADDR_WIDTH-1:0] win_top, win_bot;
    logic                  in_kernel_win;

    assign win_top       = is_kernel_i ? K_TOP : U_TOP;
    assign win_bot       = is_kernel_i ? K_BOT : U_BOT;
    assign in_kernel_win = (address_i >= K_TOP) && (address_i <= K_BOT);

    always_comb begin
        fault_code_o = FLT_NONE;
        if (!is_kernel_i && in_kernel_win)
            fault_code_o = FLT_PRIV;
        else if (op_is_stack(op_i) && (address_i < win_top))
            fault_code_o = FLT_OVERFLOW;
        else if (op_is_stack(op_i) && (address_i > win_bot))
            fault_code_o = FLT_UNDERFLOW;
    end

    assign fault_o = (fault_code_o != FLT_NONE);

endmodule

// File: rtl/stack_memory_responder.sv
// Data-memory responder: checks stack/privilege rules, drives a single-port sync RAM, answers via valid/ready.
// Optional STACK_WATERMARK_EN adds per-mode deepest-PUSH watermark outputs.
module stack_memory_responder
    import stack_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned READ_LATENCY        = 1,
    parameter int unsigned KERNEL_STACK_TOP    = DEF_KERNEL_STACK_TOP,
    parameter int unsigned KERNEL_STACK_BOTTOM = DEF_KERNEL_STACK_BOTTOM,
    parameter int unsigned USER_STACK_TOP      = DEF_USER_STACK_TOP,
    parameter int unsigned USER_STACK_BOTTOM   = DEF_USER_STACK_BOTTOM
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_is_kernel,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    output logic [1:0]            resp_fault_code,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef STACK_WATERMARK_EN
    ,
    output logic [ADDR_WIDTH-1:0] kernel_watermark,
    output logic [ADDR_WIDTH-1:0] user_watermark
`endif
);

    localparam logic [2:0] RL_CNT = 3'(READ_LATENCY);

    logic [1:0]            state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  fault_q, fault_d;
    logic [1:0]            code_q, code_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  chk_fault;
    logic [1:0]            chk_code;

    stack_access_checker #(
        .ADDR_WIDTH          (ADDR_WIDTH),
        .KERNEL_STACK_TOP    (KERNEL_STACK_TOP),
        .KERNEL_STACK_BOTTOM (KERNEL_STACK_BOTTOM),
        .USER_STACK_TOP      (USER_STACK_TOP),
        .USER_STACK_BOTTOM   (USER_STACK_BOTTOM)
    ) u_checker (
        .op_i         (req_op),
        .address_i    (req_address),
        .is_kernel_i  (req_is_kernel),
        .fault_o      (chk_fault),
        .fault_code_o (chk_code)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        rdata_d      = rdata_q;
        fault_d      = fault_q;
        code_d       = code_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    rdata_d = '0;
                    fault_d = chk_fault;
                    code_d  = chk_code;
                    if (chk_fault) begin
                        resp_valid_d = 1'b1;
                        state_d      = ST_RESPOND;
                    end else begin
                        mem_addr_d = req_address;
                        if (op_is_write(req_op))
                            mem_wdata_d = req_wdata;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_is_write(op_q)) begin
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESPOND;
                end else begin
                    cnt_d   = RL_CNT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Counter hits zero this cycle: RAM data is valid now.
                if (cnt_q == 3'd1) begin
                    rdata_d      = mem_rdata;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LOAD;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            fault_q      <= 1'b0;
            code_q       <= FLT_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            fault_q      <= fault_d;
            code_q       <= code_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Strobes decode from state so an async reset drops them at once.
    assign mem_write_enable = (state_q == ST_ISSUE) &&  op_is_write(op_q);
    assign mem_read_enable  = (state_q == ST_ISSUE) && !op_is_write(op_q);
    assign req_ready        = (state_q == ST_IDLE);
    assign mem_address      = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = rdata_q;
    assign resp_fault       = fault_q;
    assign resp_fault_code  = code_q;

`ifdef STACK_WATERMARK_EN
    localparam logic [ADDR_WIDTH-1:0] K_WM_RST = ADDR_WIDTH'(KERNEL_STACK_BOTTOM + 1);
    localparam logic [ADDR_WIDTH-1:0] U_WM_RST = ADDR_WIDTH'(USER_STACK_BOTTOM + 1);

    logic                  kern_q;
    logic [ADDR_WIDTH-1:0] kwm_q, uwm_q;

    // Only clean requests reach ISSUE, so faulting PUSHes never move a watermark.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kern_q <= 1'b0;
            kwm_q  <= K_WM_RST;
            uwm_q  <= U_WM_RST;
        end else begin
            if (req_ready && req_valid)
                kern_q <= req_is_kernel;
            if ((state_q == ST_ISSUE) && (op_q == OP_PUSH)) begin
                if (kern_q && (mem_addr_q < kwm_q))
                    kwm_q <= mem_addr_q;
                if (!kern_q && (mem_addr_q < uwm_q))
                    uwm_q <= mem_addr_q;
            end
        end
    end

    assign kernel_watermark = kwm_q;
    assign user_watermark   = uwm_q;
`endif

endmodule

// File: tb/tb_stack_memory_responder.sv
// Bench for stack_memory_responder: directed table, randomized transactions vs. a rule-level model, reset-in-WAIT.
module tb_stack_memory_responder;
    import stack_memory_pkg::*;

    localparam int RL  = 1;
    localparam int RL4 = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        req_valid = 0, req_is_kernel = 0, resp_ready = 0;
    logic [1:0]  req_op = 0;
    logic [31:0] req_address = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_fault, mem_write_enable, mem_read_enable;
    logic [1:0]  resp_fault_code;
    logic [31:0] resp_rdata, mem_address, mem_wdata, mem_rdata;

    logic        b_req_valid = 0, b_req_is_kernel = 0, b_resp_ready = 0;
    logic [1:0]  b_req_op = 0;
    logic [31:0] b_req_address = 0, b_req_wdata = 0;
    logic        b_req_ready, b_resp_valid, b_resp_fault, b_mem_write_enable, b_mem_read_enable;
    logic [1:0]  b_resp_fault_code;
    logic [31:0] b_resp_rdata, b_mem_address, b_mem_wdata, b_mem_rdata;
`ifdef STACK_WATERMARK_EN
    logic [31:0] kwm, uwm, b_kwm, b_uwm;
`endif

    stack_memory_responder #(.READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_address(req_address), .req_wdata(req_wdata), .req_is_kernel(req_is_kernel),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .resp_fault_code(resp_fault_code),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_rdata(mem_rdata)
`ifdef STACK_WATERMARK_EN
        , .kernel_watermark(kwm), .user_watermark(uwm)
`endif
    );

    stack_memory_responder #(.READ_LATENCY(RL4)) dut4 (
        .clock(clock), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_op(b_req_op),
        .req_address(b_req_address), .req_wdata(b_req_wdata), .req_is_kernel(b_req_is_kernel),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_fault(b_resp_fault), .resp_fault_code(b_resp_fault_code),
        .mem_address(b_mem_address), .mem_wdata(b_mem_wdata),
        .mem_write_enable(b_mem_write_enable), .mem_read_enable(b_mem_read_enable),
        .mem_rdata(b_mem_rdata)
`ifdef STACK_WATERMARK_EN
        , .kernel_watermark(b_kwm), .user_watermark(b_uwm)
`endif
    );

    // RAM models: junk on the read port whenever no read is in flight.
    logic [31:0] ram [0:16383];
    logic [31:0] rpipe [RL];
    logic [31:0] bpipe [RL4];
    assign mem_rdata   = rpipe[RL-1];
    assign b_mem_rdata = bpipe[RL4-1];

    always @(posedge clock) begin
        if (mem_write_enable) ram[mem_address[13:0]] <= mem_wdata;
        rpipe[0] <= mem_read_enable ? ram[mem_address[13:0]] : $urandom;
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
        bpipe[0] <= b_mem_read_enable ? (b_mem_address ^ 32'hA5A5A5A5) : $urandom;
        for (int i = 1; i < RL4; i++) bpipe[i] <= bpipe[i-1];
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: access rules, expected memory contents and watermarks.
    logic [31:0] exp_mem [0:16383];
    logic [31:0] m_kwm = 32'd6144;
    logic [31:0] m_uwm = 32'd8192;

    function automatic logic [1:0] model_code(input logic [1:0] op, input logic [31:0] a, input logic k);
        longint ua, lo, hi;
        ua = longint'(a);
        lo = k ? 4096 : 6144;
        hi = k ? 6143 : 8191;
        if (!k && ua >= 4096 && ua <= 6143) return 2'd3;
        if (op == OP_PUSH || op == OP_POP) begin
            if (ua < lo) return 2'd1;
            if (ua > hi) return 2'd2;
        end
        return 2'd0;
    endfunction

    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic k, input logic [1:0] ecode, input logic [31:0] erdata,
                          input int hold, input bit poke);
        int n, wes, res, elat;
        logic [31:0] wa, wdd, ra;
        bit iswr, clean;
        iswr  = (op == OP_STORE) || (op == OP_PUSH);
        clean = (ecode == 2'd0);
        elat  = !clean ? 1 : (iswr ? 2 : RL + 2);
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clock); #1; n++; end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1; req_op = op; req_address = addr; req_wdata = wd; req_is_kernel = k;
        @(posedge clock); #1;
        req_valid = 0; req_op = 2'($urandom); req_address = $urandom; req_wdata = $urandom;
        req_is_kernel = 1'($urandom);
        n = 1; wes = 0; res = 0; wa = 0; wdd = 0; ra = 0;
        while (!resp_valid && n < 20) begin
            if (mem_write_enable) begin wes++; wa = mem_address; wdd = mem_wdata; end
            if (mem_read_enable)  begin res++; ra = mem_address; end
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            @(posedge clock); #1; n++;
        end
        chk("latency", 32'(n), 32'(elat));
        chk("resp_fault", 32'(resp_fault), 32'(!clean));
        chk("fault_code", 32'(resp_fault_code), 32'(ecode));
        chk("resp_rdata", resp_rdata, erdata);
        chk("we_pulses", 32'(wes), (clean && iswr) ? 32'd1 : 32'd0);
        chk("re_pulses", 32'(res), (clean && !iswr) ? 32'd1 : 32'd0);
        if (clean && iswr) begin
            chk("wr_addr", wa, addr);
            chk("wr_data", wdd, wd);
            exp_mem[addr[13:0]] = wd;
            if (op == OP_PUSH) begin
                if (k && addr < m_kwm) m_kwm = addr;
                if (!k && addr < m_uwm) m_uwm = addr;
            end
        end
        if (clean && !iswr) chk("rd_addr", ra, addr);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid = 1; req_op = OP_STORE; req_address = 32'd100;
                req_wdata = 32'hBAD0BAD0; req_is_kernel = 1;
            end
            @(posedge clock); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, erdata);
            chk("hold_code", 32'(resp_fault_code), 32'(ecode));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_no_strobe", 32'(mem_write_enable | mem_read_enable), 32'd0);
        end
        req_valid = 0; resp_ready = 1;
        @(posedge clock); #1;
        resp_ready = 0;
        chk("resp_valid_clear", 32'(resp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
`ifdef STACK_WATERMARK_EN
        chk("kernel_wm", kwm, m_kwm);
        chk("user_wm", uwm, m_uwm);
`endif
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        kern;
        logic [1:0]  code;
        logic [31:0] rdata;
        int          hold;
        bit          poke;
    } vec_t;

    vec_t vt [19];

    initial begin
        int n;
        bit bad;
        for (int i = 0; i < 16384; i++) begin ram[i] = '0; exp_mem[i] = '0; end
        for (int i = 0; i < RL; i++) rpipe[i] = '0;
        for (int i = 0; i < RL4; i++) bpipe[i] = '0;

        vt[0]  = '{OP_PUSH,  32'd8191, 32'hDEADBEEF, 1'b0, 2'd0, 32'h0,        0, 1'b0};
        vt[1]  = '{OP_POP,   32'd8191, 32'h0,        1'b0, 2'd0, 32'hDEADBEEF, 5, 1'b1};
        vt[2]  = '{OP_LOAD,  32'd100,  32'h0,        1'b1, 2'd0, 32'h0,        0, 1'b0};
        vt[3]  = '{OP_PUSH,  32'd5000, 32'h55555555, 1'b0, 2'd3, 32'h0,        1, 1'b0};
        vt[4]  = '{OP_PUSH,  32'd4095, 32'h1,        1'b1, 2'd1, 32'h0,        0, 1'b0};
        vt[5]  = '{OP_POP,   32'd6144, 32'h0,        1'b1, 2'd2, 32'h0,        0, 1'b0};
        vt[6]  = '{OP_STORE, 32'd5000, 32'h12345678, 1'b1, 2'd0, 32'h0,        0, 1'b0};
        vt[7]  = '{OP_LOAD,  32'd5000, 32'h0,        1'b1, 2'd0, 32'h12345678, 2, 1'b0};
        vt[8]  = '{OP_LOAD,  32'd5000, 32'h0,        1'b0, 2'd3, 32'h0,        0, 1'b0};
        vt[9]  = '{OP_STORE, 32'd0,    32'hCAFEF00D, 1'b0, 2'd0, 32'h0,        0, 1'b0};
        vt[10] = '{OP_LOAD,  32'd0,    32'h0,        1'b0, 2'd0, 32'hCAFEF00D, 0, 1'b0};
        vt[11] = '{OP_POP,   32'd6143, 32'h0,        1'b0, 2'd3, 32'h0,        0, 1'b0};
        vt[12] = '{OP_PUSH,  32'd6144, 32'h11111111, 1'b0, 2'd0, 32'h0,        0, 1'b0};
        vt[13] = '{OP_POP,   32'd6143, 32'h0,        1'b1, 2'd0, 32'h0,        0, 1'b0};
        vt[14] = '{OP_PUSH,  32'd8192, 32'h2,        1'b0, 2'd2, 32'h0,        0, 1'b0};
        vt[15] = '{OP_PUSH,  32'd0,    32'h3,        1'b0, 2'd1, 32'h0,        0, 1'b0};
        vt[16] = '{OP_PUSH,  32'd4096, 32'h00002222, 1'b1, 2'd0, 32'h0,        0, 1'b0};
        vt[17] = '{OP_LOAD,  32'd4096, 32'h0,        1'b0, 2'd3, 32'h0,        0, 1'b0};
        vt[18] = '{OP_POP,   32'd6144, 32'h0,        1'b0, 2'd0, 32'h11111111, 1, 1'b0};

        #2 reset = 0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_fault", 32'({resp_fault, resp_fault_code}), 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_strobes", 32'({mem_write_enable, mem_read_enable}), 32'd0);
`ifdef STACK_WATERMARK_EN
        chk("rst_kernel_wm", kwm, 32'd6144);
        chk("rst_user_wm", uwm, 32'd8192);
`endif
        @(negedge clock); reset = 1;
        @(posedge clock); #1;

        foreach (vt[i])
            do_req(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].kern, vt[i].code, vt[i].rdata,
                   vt[i].hold, vt[i].poke);

        for (int i = 0; i < 200; i++) begin
            logic [1:0]  op;
            logic [31:0] a, wd, erd;
            logic        k;
            logic [1:0]  ec;
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(3900, 8400));
            wd = $urandom;
            k  = 1'($urandom_range(0, 1));
            ec = model_code(op, a, k);
            erd = (ec == 2'd0 && (op == OP_LOAD || op == OP_POP)) ? exp_mem[a[13:0]] : 32'd0;
            do_req(op, a, wd, k, ec, erd, $urandom_range(0, 2), 1'b0);
        end

        // READ_LATENCY=4 instance: full read latency, then a reset landing in WAIT.
        b_req_valid = 1; b_req_op = OP_POP; b_req_address = 32'd4096; b_req_is_kernel = 1;
        @(posedge clock); #1;
        b_req_valid = 0;
        n = 1;
        while (!b_resp_valid && n < 20) begin @(posedge clock); #1; n++; end
        chk("rl4_latency", 32'(n), 32'(RL4 + 2));
        chk("rl4_rdata", b_resp_rdata, 32'd4096 ^ 32'hA5A5A5A5);
        b_resp_ready = 1; @(posedge clock); #1; b_resp_ready = 0;
`ifdef STACK_WATERMARK_EN
        b_req_valid = 1; b_req_op = OP_PUSH; b_req_address = 32'd5000; b_req_wdata = 32'h7;
        @(posedge clock); #1;
        b_req_valid = 0;
        n = 1;
        while (!b_resp_valid && n < 20) begin @(posedge clock); #1; n++; end
        b_resp_ready = 1; @(posedge clock); #1; b_resp_ready = 0;
        chk("rl4_kernel_wm", b_kwm, 32'd5000);
`endif
        b_req_valid = 1; b_req_op = OP_POP; b_req_address = 32'd4100; b_req_is_kernel = 1;
        @(posedge clock); #1;
        b_req_valid = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("rl4_busy_in_wait", 32'(b_req_ready), 32'd0);
        reset = 0;
        #1;
        chk("mid_rst_req_ready", 32'(b_req_ready), 32'd1);
        chk("mid_rst_resp", 32'({b_resp_valid, b_resp_fault, b_resp_fault_code}), 32'd0);
        chk("mid_rst_rdata", b_resp_rdata, 32'd0);
        chk("mid_rst_mem", b_mem_address | b_mem_wdata, 32'd0);
        chk("mid_rst_strobes", 32'({b_mem_write_enable, b_mem_read_enable}), 32'd0);
`ifdef STACK_WATERMARK_EN
        chk("mid_rst_kernel_wm", b_kwm, 32'd6144);
        chk("mid_rst_user_wm", b_uwm, 32'd8192);
`endif
        @(negedge clock); reset = 1;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clock); #1;
            if (b_resp_valid || b_mem_read_enable || !b_req_ready) bad = 1;
        end
        chk("no_stale_response", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
